// File: rtl/mux_sel_pkg.sv
// Shared constants and types for the 4-channel mux-select round-robin arbiter.
package mux_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef logic [NUM_CH-1:0] onehot_t;

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... modulo 4.
module rr_pick
    import mux_sel_pkg::*;
(
    input  onehot_t          req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down to the nearest so the nearest set bit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter producing a glitch-free 2-bit mux select plus one-hot grant.
// Optional MUX_SEL_LOCK_EN adds a lock input that holds the grant past its dwell time.
module mux_sel_rr_arbiter
    import mux_sel_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               done,
`ifdef MUX_SEL_LOCK_EN
    input  logic               lock,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_CH-1:0]  grant,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    onehot_t            grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0]   pick;
    logic               any;
    logic               release_now;
    logic               hold_zero;

    rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

`ifdef MUX_SEL_LOCK_EN
    assign release_now = !req[sel_q] || (!lock && ((cnt_q == '0) || done));
    assign hold_zero   = lock && (cnt_q == '0);
`else
    assign release_now = !req[sel_q] || (cnt_q == '0) || done;
    assign hold_zero   = 1'b0;
`endif

    // Every release passes through IDLE for one cycle, so sel never switches mid-grant.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    last_d  = pick;
                    grant_d = onehot_t'(1) << pick;
                    busy_d  = 1'b1;
                    cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!hold_zero) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last resets to 3 so channel 0 is scanned first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: directed scenarios plus randomized traffic vs a cycle model.
module tb_mux_sel_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       done;
    logic       lock;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;

    int checks;
    int failures;

    // Reference state: whether a grant is live, its channel, last winner, cycles left in the window.
    bit m_busy;
    int m_sel;
    int m_last;
    int m_rem;

    mux_sel_rr_arbiter #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .dwell (dwell),
        .done  (done),
`ifdef MUX_SEL_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = 3;
        m_rem  = 0;
    endfunction

    function automatic bit lock_active();
`ifdef MUX_SEL_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_update();
        int  found;
        bit  timer_up;
        bit  rel;
        if (!m_busy) begin
            found = -1;
            for (int k = 1; k <= 4; k++) begin
                if (found < 0 && req[(m_last + k) % 4]) found = (m_last + k) % 4;
            end
            if (found >= 0) begin
                m_busy = 1'b1;
                m_sel  = found;
                m_last = found;
                m_rem  = (dwell == 0) ? 1 : int'(dwell);
            end
        end else begin
            timer_up = (m_rem <= 1) || done;
            rel = !req[m_sel] || (timer_up && !lock_active());
            if (rel) begin
                m_busy = 1'b0;
            end else if (m_rem > 1) begin
                m_rem = m_rem - 1;
            end
        end
    endfunction

    task automatic step(input string tag);
        logic [3:0] exp_grant;
        model_update();
        @(posedge clk);
        #1;
        exp_grant = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        checks++;
        if (busy !== m_busy) begin
            failures++;
            $display("[TB] FAIL %s busy: got %b expected %b", tag, busy, m_busy);
        end
        checks++;
        if (grant !== exp_grant) begin
            failures++;
            $display("[TB] FAIL %s grant: got %b expected %b", tag, grant, exp_grant);
        end
        checks++;
        if (sel !== 2'(m_sel)) begin
            failures++;
            $display("[TB] FAIL %s sel: got %0d expected %0d", tag, sel, m_sel);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        dwell = 4'd0;
        done  = 1'b0;
        lock  = 1'b0;
        #2;
        checks++;
        if (sel !== 2'd0 || grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values: got sel=%0d grant=%b busy=%b expected 0 0000 0", sel, grant, busy);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        step("reset_idle");
    endtask

    task automatic test_single();
        logic [3:0] exp_busy;
        do_reset();
        req      = 4'b0100;
        dwell    = 4'd3;
        exp_busy = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            step("single");
            checks++;
            if (busy !== exp_busy[i] || sel !== 2'd2) begin
                failures++;
                $display("[TB] FAIL single_window c%0d: got busy=%b sel=%0d expected busy=%b sel=2",
                         i, busy, sel, exp_busy[i]);
            end
        end
        req = 4'b0000;
        step("single_drain");
    endtask

    task automatic test_rotation();
        int exp_sel[13]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        bit exp_busy[13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        do_reset();
        req   = 4'b1111;
        dwell = 4'd2;
        for (int i = 0; i < 13; i++) begin
            step("rotation");
            checks++;
            if (sel !== 2'(exp_sel[i]) || busy !== exp_busy[i]) begin
                failures++;
                $display("[TB] FAIL rotation c%0d: got sel=%0d busy=%b expected sel=%0d busy=%b",
                         i, sel, busy, exp_sel[i], exp_busy[i]);
            end
        end
        req = 4'b0000;
        step("rotation_drain");
        step("rotation_drain");
    endtask

    task automatic test_done();
        do_reset();
        req   = 4'b0010;
        dwell = 4'd8;
        step("done_c1");
        step("done_c2");
        step("done_c3");
        done = 1'b1;
        step("done_release");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_release: got busy=%b expected 0", busy);
        end
        done = 1'b0;
        req  = 4'b1111;
        step("done_next");
        checks++;
        if (sel !== 2'd2 || grant !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL done_next_pick: got sel=%0d grant=%b expected 2 0100", sel, grant);
        end
        req = 4'b0000;
        step("done_drain");
        step("done_drain");
    endtask

    task automatic test_req_drop();
        do_reset();
        req   = 4'b1000;
        dwell = 4'd5;
        step("drop_c1");
        step("drop_c2");
        req = 4'b0001;
        step("drop_release");
        checks++;
        if (busy !== 1'b0 || sel !== 2'd3) begin
            failures++;
            $display("[TB] FAIL drop_release: got busy=%b sel=%0d expected 0 3", busy, sel);
        end
        step("drop_next");
        checks++;
        if (sel !== 2'd0 || grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL drop_next: got sel=%0d grant=%b expected 0 0001", sel, grant);
        end
        req = 4'b0000;
        step("drop_drain");
        step("drop_drain");
    endtask

    task automatic test_min_dwell_async_reset();
        do_reset();
        req   = 4'b0010;
        dwell = 4'd0;
        step("dwell0_c1");
        step("dwell0_gap");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dwell0_length: got busy=%b expected 0", busy);
        end
        step("dwell0_regrant");
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got sel=%0d grant=%b busy=%b expected 0 0000 0", sel, grant, busy);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        req = 4'b0000;
        step("after_reset");
    endtask

`ifdef MUX_SEL_LOCK_EN
    task automatic test_lock();
        do_reset();
        req   = 4'b0001;
        dwell = 4'd2;
        lock  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("lock_hold");
            checks++;
            if (busy !== 1'b1 || grant !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL lock_hold c%0d: got busy=%b grant=%b expected 1 0001", i, busy, grant);
            end
        end
        lock = 1'b0;
        step("lock_release");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lock_release: got busy=%b expected 0", busy);
        end
        req = 4'b0000;
        step("lock_drain");
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) req = req | (busy ? grant : 4'b0000);
            dwell = 4'($urandom_range(0, 5));
            done  = ($urandom_range(0, 7) == 0);
            lock  = ($urandom_range(0, 1) == 1);
            step("random");
        end
        req  = 4'b0000;
        done = 1'b0;
        lock = 1'b0;
        step("random_drain");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_rotation();
        test_done();
        test_req_drop();
        test_min_dwell_async_reset();
`ifdef MUX_SEL_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_rr_arbiter.md
Name: mux_sel_rr_arbiter

Overview:
- 4-channel round-robin arbiter directly upstream of the 4-to-1 mux.
- Produces the 2-bit select (sel[1:0]) driving the mux, plus a one-hot grant back to the requesters.
- Holds each grant for a programmable dwell time, then rotates fairly to the next requesting channel.
- Guarantees sel is stable for the whole grant window, so the downstream mux output never glitches between channels mid-transfer.

Parameters:
- DWELL_W, 4, width of the dwell counter and of the dwell input.
- NUM_CH, 4, number of channels; fixed at 4 to match the 2-bit mux select; any other value is illegal.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  per-channel request; bit i requests mux input i (0=a, 1=b, 2=c, 3=d).
- dwell  input  DWELL_W  grant length in cycles; sampled at grant start; 0 is treated as 1.
- done  input  1  early release of the current grant; ignored in IDLE.
- sel  output  2  mux select; registered.
- grant  output  4  one-hot grant, equal to 1<<sel while busy, otherwise 0; registered.
- busy  output  1  high while a grant is active; registered.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: sel=0, grant=0, busy=0, state=IDLE, dwell counter=0, last pointer=3 (so channel 0 has first priority).
- FSM states:
  - IDLE: if req!=0, pick the first set bit scanning last+1, last+2, ... modulo 4. Next cycle: state=GRANT, sel=pick, grant=1<<pick, busy=1, cnt=max(dwell,1)-1, last=pick. If req==0, stay in IDLE; sel holds its previous value.
  - GRANT: each cycle, release if any of: cnt==0, done==1, or req[sel]==0. Otherwise decrement cnt.
  - Release: next cycle state=IDLE, grant=0, busy=0, sel unchanged. The mandatory one-cycle IDLE gap guarantees a clean channel switch.
- Latency: req rising in IDLE at edge N gives grant at edge N+1. For dwell=D with req held and done low, grant lasts exactly max(D,1) cycles.
- Simultaneous release conditions: treated as a single release; no extra effect.
- Requests changing during GRANT only affect the next pick. A new request on the granted channel does not extend the grant.
- No starvation: with all 4 requests held, grants rotate 0,1,2,3,0 with one idle cycle between grants.
- dwell changes during GRANT are ignored; the value is sampled only at grant start.
- Reset mid-grant: outputs return to reset values immediately (asynchronously). The first grant after reset goes to the lowest set req bit starting from channel 0.
- cnt never wraps; it saturates at 0 in IDLE.

Optional Feature:
- Macro MUX_SEL_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 in GRANT, release via cnt==0 or done is suppressed and cnt holds at 0. Release on req[sel]==0 still applies. Deasserting lock with cnt==0 releases on that cycle.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux_sel_pkg:
  - NUM_CH=4 and SEL_W=2 constants.
  - state enum {IDLE, GRANT}.
  - onehot_t typedef (logic [3:0]).
- Sub-module rr_pick: purely combinational rotate-and-priority picker. Inputs req[3:0] and last[1:0]; outputs pick[1:0] and any.
- The FSM, counter and output registers live in the top module.

Test Plan:
- Reset, then req=4'b0100, dwell=3 → grant=4'b0100 and sel=2 for exactly 3 cycles starting 1 cycle after req, then 1 cycle of busy=0 with sel still 2.
- req=4'b1111 held, dwell=2 → sel sequence 0,0,-,1,1,-,2,2,-,3,3,-,0 (- = idle gap, grant=0).
- Granted channel 1 with dwell=8; assert done on cycle 3 of the grant → busy drops next cycle; the next pick starts from channel 2.
- Granted channel 3 with dwell=5; drop req[3] on cycle 2 → release next cycle; req=4'b0001 then grants channel 0.
- dwell=0 with req=4'b0010 → grant lasts exactly 1 cycle; assert rst_n=0 mid-grant → grant=0, sel=0 asynchronously, before the next clock edge.
- MUX_SEL_LOCK_EN defined, dwell=2, lock=1 held 6 cycles → grant held 6 cycles; lock drops → release on that cycle, idle gap follows.
